// File: rtl/text_tile_buffer.sv
// text_tile_buffer
//   Character tile store for the VGA text-mode controller: COLS x ROWS tiles,
//   DATA_W-bit char code per tile. The host/UART side writes tiles and the
//   pixel pipeline reads them by (col,row). Writes are synchronous, the read
//   is registered (1-cycle latency), and a clear sequencer zeroes the whole
//   store after every reset.
//
//   Optional feature macro: WR_BYPASS_EN
//     defined   -> same-cycle write+read to one valid tile returns din (write-first)
//     undefined -> read-before-write, dout shows the old contents
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high (restarts the clear)
//   wr_en  in   write strobe
//   col_w  in   write column
//   row_w  in   write row
//   din    in   write data
//   col_r  in   read column
//   row_r  in   read row
//   dout   out  registered read data, 0 for out-of-range or while busy
//   busy   out  high while the clear sequencer runs
module text_tile_buffer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int DATA_W = 7,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [COL_W-1:0]  col_w,
    input  logic [ROW_W-1:0]  row_w,
    input  logic [DATA_W-1:0] din,
    input  logic [COL_W-1:0]  col_r,
    input  logic [ROW_W-1:0]  row_r,
    output logic [DATA_W-1:0] dout,
    output logic              busy
);

    localparam int ADDR_W = 12;
    localparam int DEPTH  = COLS * ROWS;

    localparam logic [COL_W-1:0]  COLS_L  = COL_W'(COLS);
    localparam logic [ROW_W-1:0]  ROWS_L  = ROW_W'(ROWS);
    localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_ok, rd_ok, host_we, mem_we;
    logic [ADDR_W-1:0]   addr_w, addr_r, mem_addr;
    logic [DATA_W-1:0]   mem_din;

    // Constant multiply by COLS; for 80 this reduces to (row<<6)+(row<<4).
    assign addr_w = ADDR_W'(row_w) * COLS_A + ADDR_W'(col_w);
    assign addr_r = ADDR_W'(row_r) * COLS_A + ADDR_W'(col_r);

    assign wr_ok = (col_w < COLS_L) && (row_w < ROWS_L);
    assign rd_ok = (col_r < COLS_L) && (row_r < ROWS_L);

    // Host writes are dropped, not queued, while the clear runs.
    assign host_we = wr_en && wr_ok && !busy;

    // The clear sequencer and the host share the single RAM write port.
    // Nothing is written on a reset edge.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_w;
        mem_din  = din;
        if (!rst) begin
            if (busy) begin
                mem_we   = 1'b1;
                mem_addr = ptr;
                mem_din  = '0;
            end else begin
                mem_we   = host_we;
            end
        end
    end

    // Clear sequencer: one tile per cycle, ptr 0..DEPTH-1, then idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            busy  <= 1'b1;
            ptr   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (ptr == LAST_A) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        ptr   <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage: single write port, no reset, no async read.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_din;
    end

    // Registered read port.
`ifdef WR_BYPASS_EN
    always_ff @(posedge clk) begin
        if (rst || busy || !rd_ok)
            dout <= '0;
        else if (host_we && (addr_w == addr_r))
            dout <= din;
        else
            dout <= mem[addr_r];
    end
`else
    always_ff @(posedge clk) begin
        if (rst || busy || !rd_ok)
            dout <= '0;
        else
            dout <= mem[addr_r];
    end
`endif

endmodule

// File: tb/tb_text_tile_buffer.sv
module tb_text_tile_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [6:0] col_w, col_r, din, dout;
    logic [4:0] row_w, row_r;
    logic       busy;

    int         total = 0;
    int         bad   = 0;
    logic [6:0] model [2400];
    logic [6:0] sb [$];

    text_tile_buffer dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .col_w (col_w),
        .row_w (row_w),
        .din   (din),
        .col_r (col_r),
        .row_r (row_r),
        .dout  (dout),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // One idle-state cycle: drive ports, push the expected dout, update model.
    task automatic drive(input logic we, input int cw, input int rw, input int d,
                         input int cr, input int rr);
        logic [6:0] e;
        logic       wv;
        wr_en = we;
        col_w = 7'(cw); row_w = 5'(rw); din = 7'(d);
        col_r = 7'(cr); row_r = 5'(rr);
        wv = we && (cw < 80) && (rw < 30);
        e  = (cr < 80 && rr < 30) ? model[rr*80 + cr] : 7'h00;
`ifdef WR_BYPASS_EN
        if (wv && cw == cr && rw == rr) e = 7'(d);
`endif
        sb.push_back(e);
        if (wv) model[rw*80 + cw] = 7'(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        logic [6:0] e;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        total++;
        if (dout !== 7'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", dout); end
        n = 1;
        while (busy === 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            if (busy === 1'b1) n++;
            if (n == 1200) begin
                total++;
                if (dout !== 7'h00) begin bad++; $display("FAIL clear_dout: got %h want 00", dout); end
            end
        end
        total++;
        if (n != 2400) begin bad++; $display("FAIL clear_len: got %0d want 2400", n); end
        for (int i = 0; i < 2400; i++) model[i] = 7'h00;
        drive(1'b0, 0, 0, 0, 0, 0);
        drive(1'b0, 0, 0, 0, 79, 29);
        repeat (2) begin
            e = sb.pop_front();
            total++;
            if (dout !== e && sb.size() == 0) begin bad++; $display("FAIL clear_read: got %h want %h", dout, e); end
            else if (dout !== e) begin bad++; $display("FAIL clear_read: got %h want %h", dout, e); end
        end
    endtask

    task automatic test_corner_write;
        logic [6:0] e;
        drive(1'b1, 79, 29, 1, 0, 0);
        e = sb.pop_front(); total++;
        if (dout !== e) begin bad++; $display("FAIL corner_pre: got %h want %h", dout, e); end
        drive(1'b0, 0, 0, 0, 79, 29);
        e = sb.pop_front(); total++;
        if (dout !== e) begin bad++; $display("FAIL corner_read: got %h want %h", dout, e); end
        total++;
        if (e !== 7'h01) begin bad++; $display("FAIL corner_model: got %h want 01", e); end
    endtask

    task automatic test_fill;
        logic [6:0] e;
        int w;
        for (int i = 0; i < 2400; i++) begin
            w = 2399 - i;
            drive(1'b1, w % 80, w / 80, (i + 1) & 127, i % 80, i / 80);
            e = sb.pop_front(); total++;
            if (dout !== e) begin
                bad++;
                if (bad < 20) $display("FAIL fill[%0d]: got %h want %h", i, dout, e);
            end
        end
    endtask

    task automatic test_out_of_range;
        logic [6:0] e;
        drive(1'b1, 80, 0, 7'h55, 80, 0);
        e = sb.pop_front(); total++;
        if (dout !== e) begin bad++; $display("FAIL oor_col: got %h want %h", dout, e); end
        drive(1'b1, 0, 30, 7'h55, 0, 30);
        e = sb.pop_front(); total++;
        if (dout !== e) begin bad++; $display("FAIL oor_row: got %h want %h", dout, e); end
        // (80,0) would alias tile (0,1) if the range check were missing
        drive(1'b0, 0, 0, 0, 0, 1);
        e = sb.pop_front(); total++;
        if (dout !== e) begin bad++; $display("FAIL oor_alias: got %h want %h", dout, e); end
        drive(1'b0, 0, 0, 0, 79, 29);
        e = sb.pop_front(); total++;
        if (dout !== e) begin bad++; $display("FAIL oor_last: got %h want %h", dout, e); end
    endtask

    task automatic test_same_cycle;
        logic [6:0] e;
        drive(1'b1, 10, 5, 3, 0, 0);
        e = sb.pop_front(); total++;
        if (dout !== e) begin bad++; $display("FAIL rw_setup: got %h want %h", dout, e); end
        drive(1'b1, 10, 5, 9, 10, 5);
        e = sb.pop_front(); total++;
`ifdef WR_BYPASS_EN
        if (e !== 7'h09) begin bad++; $display("FAIL rw_model: got %h want 09", e); end
`else
        if (e !== 7'h03) begin bad++; $display("FAIL rw_model: got %h want 03", e); end
`endif
        total++;
        if (dout !== e) begin bad++; $display("FAIL rw_same: got %h want %h", dout, e); end
        drive(1'b0, 0, 0, 0, 10, 5);
        e = sb.pop_front(); total++;
        if (dout !== e) begin bad++; $display("FAIL rw_after: got %h want %h", dout, e); end
    endtask

    task automatic test_back_to_back;
        logic [6:0] e;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 20 + i, 7, 100 + i, 20 + i - 1, 7);
            e = sb.pop_front(); total++;
            if (dout !== e) begin bad++; $display("FAIL b2b[%0d]: got %h want %h", i, dout, e); end
        end
    endtask

    task automatic test_clear_abort;
        int n;
        logic [6:0] e;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wr_en = 1'b1; col_w = 7'd2; row_w = 5'd2; din = 7'h7f;
        col_r = 7'd2; row_r = 5'd2;
        repeat (1000) begin @(posedge clk); #1; end
        total++;
        if (busy !== 1'b1 || dout !== 7'h00) begin
            bad++; $display("FAIL abort_mid: busy=%b dout=%h want busy=1 dout=00", busy, dout);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL abort_rst: got %b want 1", busy); end
        n = 1;
        while (busy === 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            if (busy === 1'b1) n++;
        end
        wr_en = 1'b0;
        total++;
        if (n != 2400) begin bad++; $display("FAIL abort_len: got %0d want 2400", n); end
        for (int i = 0; i < 2400; i++) model[i] = 7'h00;
        drive(1'b0, 0, 0, 0, 2, 2);
        e = sb.pop_front(); total++;
        if (dout !== e) begin bad++; $display("FAIL abort_lost: got %h want %h", dout, e); end
        drive(1'b0, 0, 0, 0, 10, 5);
        e = sb.pop_front(); total++;
        if (dout !== e) begin bad++; $display("FAIL abort_clr: got %h want %h", dout, e); end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0;
        col_w = '0; row_w = '0; din = '0; col_r = '0; row_r = '0;
        for (int i = 0; i < 2400; i++) model[i] = 7'h00;
        test_reset;
        test_corner_write;
        test_fill;
        test_out_of_range;
        test_same_cycle;
        test_back_to_back;
        test_clear_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
